// File: rtl/full_sub.sv
// full_sub: registered WIDTH-bit ripple-borrow subtractor computing a - b - bin.
// The chain is built from 1-bit full-subtractor cells. Results appear one cycle
// after an in_valid strobe. Nothing combinational connects the inputs to the outputs.
// Optional macro FULL_SUB_OVF_EN adds a registered signed-overflow output ovf.

// One bit of the borrow chain.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module full_sub #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef FULL_SUB_OVF_EN
   ,output logic             ovf
`endif
);
    // brw[i+1] is the borrow out of cell i; brw[0] is the external borrow-in.
    logic [WIDTH:0]   brw;
    logic [WIDTH-1:0] d_c;

    assign brw[0] = bin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            full_sub_cell u_cell (
                .a  (a[i]),
                .b  (b[i]),
                .bi (brw[i]),
                .d  (d_c[i]),
                .bo (brw[i+1])
            );
        end
    endgenerate

`ifdef FULL_SUB_OVF_EN
    // Signed overflow: the borrow into the sign cell differs from the borrow out of it.
    logic ovf_c;
    generate
        if (WIDTH >= 2) begin : g_ovf
            assign ovf_c = brw[WIDTH] ^ brw[WIDTH-1];
        end else begin : g_no_ovf
            assign ovf_c = 1'b0;
        end
    endgenerate
`endif

    // Capture the chain result on a valid strobe. Otherwise hold the old result and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef FULL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff <= d_c;
                bout <= brw[WIDTH];
`ifdef FULL_SUB_OVF_EN
                ovf  <= ovf_c;
`endif
            end
        end
    end
endmodule

// File: tb/tb_full_sub.sv
// Directed testbench for full_sub. It uses a WIDTH=1 instance and a WIDTH=8 instance.
// Inputs are driven on the falling edge. Outputs are sampled on the following falling edge.
module tb_full_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       ov1, d1, bo1;
    logic       v8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       ov8, bo8;
    logic [7:0] d8;
`ifdef FULL_SUB_OVF_EN
    logic       ovf1, ovf8;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    full_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .diff(d1), .bout(bo1)
`ifdef FULL_SUB_OVF_EN
       ,.ovf(ovf1)
`endif
    );

    full_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .diff(d8), .bout(bo8)
`ifdef FULL_SUB_OVF_EN
       ,.ovf(ovf8)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov1, d1, bo1, ov8, d8, bo8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got ov1=%b d1=%b bo1=%b ov8=%b d8=%h bo8=%b, want all 0",
                     ov1, d1, bo1, ov8, d8, bo8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_w1_sweep();
        logic [7:0] exp_d = 8'b1001_0110;
        logic [7:0] exp_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v = i[2:0];
            {a1, b1, bin1} = v;
            v1 = 1'b1;
            @(negedge clk);
            checks++;
            if ({ov1, d1, bo1} !== {1'b1, exp_d[i], exp_b[i]}) begin
                errors++;
                $display("FAIL w1_sweep[%0d]: got v=%b d=%b b=%b, want v=1 d=%b b=%b",
                         i, ov1, d1, bo1, exp_d[i], exp_b[i]);
            end
        end
        v1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        {a1, b1, bin1} = 3'b100;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        checks++;
        if ({ov1, d1, bo1} !== 3'b110) begin
            errors++;
            $display("FAIL pre_reset: got v=%b d=%b b=%b, want 1 1 0", ov1, d1, bo1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov1, d1, bo1} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%b b=%b, want 0 0 0", ov1, d1, bo1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // The first valid strobe after release must give a normal result.
        {a1, b1, bin1} = 3'b011;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        checks++;
        if ({ov1, d1, bo1} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset: got v=%b d=%b b=%b, want 1 0 1", ov1, d1, bo1);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        {a1, b1, bin1} = 3'b111;
        v1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({ov1, d1, bo1} !== 3'b111) begin
            errors++;
            $display("FAIL hold_load: got v=%b d=%b b=%b, want 1 1 1", ov1, d1, bo1);
        end
        {a1, b1, bin1} = 3'b000;
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov1, d1, bo1} !== 3'b011) begin
            errors++;
            $display("FAIL hold_keep: got v=%b d=%b b=%b, want 0 1 1", ov1, d1, bo1);
        end
    endtask

    task automatic test_w8();
        logic [7:0] ta [4] = '{8'h00, 8'h80, 8'hFF, 8'h55};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h00, 8'hAA};
        logic       tc [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        logic [7:0] ed [4] = '{8'hFF, 8'h7E, 8'hFE, 8'hAB};
        logic       eb [4] = '{1'b1,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 4; i++) begin
            a8 = ta[i]; b8 = tb[i]; bin8 = tc[i]; v8 = 1'b1;
            @(negedge clk);
            checks++;
            if ({ov8, d8, bo8} !== {1'b1, ed[i], eb[i]}) begin
                errors++;
                $display("FAIL w8[%0d]: got v=%b d=%h b=%b, want v=1 d=%h b=%b",
                         i, ov8, d8, bo8, ed[i], eb[i]);
            end
        end
        v8 = 1'b0;
        @(negedge clk);
    endtask

`ifdef FULL_SUB_OVF_EN
    task automatic test_ovf();
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        checks++;
        if ({d8, ovf8} !== {8'h7F, 1'b1}) begin
            errors++;
            $display("FAIL ovf_set: got d=%h ovf=%b, want 7f 1", d8, ovf8);
        end
        a8 = 8'h05; b8 = 8'h03;
        @(negedge clk);
        checks++;
        if ({d8, ovf8, bo8} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_clr: got d=%h ovf=%b b=%b, want 02 0 0", d8, ovf8, bo8);
        end
        a8 = 8'h7F; b8 = 8'hFF;
        @(negedge clk);
        v8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({ov8, d8, ovf8} !== {1'b0, 8'h80, 1'b1}) begin
            errors++;
            $display("FAIL ovf_hold: got v=%b d=%h ovf=%b, want 0 80 1", ov8, d8, ovf8);
        end
        {a1, b1, bin1} = 3'b011; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_w1: got %b, want 0", ovf1);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h10, 8'h00, 8'hFF, 8'h34};
        logic [7:0] tb [4] = '{8'h01, 8'hFF, 8'hFF, 8'h12};
        logic       tc [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
        logic [7:0] ed [4] = '{8'h0F, 8'h01, 8'hFF, 8'h21};
        logic       eb [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        a8 = ta[0]; b8 = tb[0]; bin8 = tc[0]; v8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                a8 = ta[k+1]; b8 = tb[k+1]; bin8 = tc[k+1];
            end else begin
                v8 = 1'b0;
            end
            checks++;
            if ({ov8, d8, bo8} !== {1'b1, ed[k], eb[k]}) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%b d=%h b=%b, want v=1 d=%h b=%b",
                         k, ov8, d8, bo8, ed[k], eb[k]);
            end
        end
        @(negedge clk);
        checks++;
        if ({ov8, d8} !== {1'b0, 8'h21}) begin
            errors++;
            $display("FAIL b2b_end: got v=%b d=%h, want v=0 d=21", ov8, d8);
        end
    endtask

    initial begin
        test_reset();
        test_w1_sweep();
        test_async_reset();
        test_hold();
        test_w8();
`ifdef FULL_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
